// File: rtl/netproto_pkg.sv
// netproto_pkg: IPv4 header layout constants and the
// transmit scheduler state encoding shared by the tx path.
package netproto_pkg;

   localparam int IPV4_HDR_WORDS  = 7;
   localparam int IPV4_LEN_WORD   = 2;
   localparam int IPV4_PROTO_WORD = 4;
   localparam int IPV4_HDR_BYTES  = 20;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD
   } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i.
// Ports: req_i requests, ptr_i start index, gnt_o one-hot,
// idx_o winner index, any_o set when any request is up.
module rr_arbiter
   import netproto_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   int   k;
   logic found;

   // Walk the requesters from ptr_i, wrapping modulo NREQ.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = int'(ptr_i) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!found && req_i[k[IW-1:0]]) begin
            found              = 1'b1;
            gnt_o[k[IW-1:0]]   = 1'b1;
            idx_o              = k[IW-1:0];
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: shares one IPv4 header source between NREQ payload
// sources, round-robin, patching total-length and protocol.
// Ports: S_HDR_* header in, S_PKT_* payload lanes in, M_AXI_* out,
// o_grant owner, o_oversize / o_hdr_err one-cycle status pulses.
module udp_tx_sched
   import netproto_pkg::*;
#(
   parameter int               NREQ        = 2,
   parameter logic [NREQ*8-1:0] PROTOS     = {8'd17, 8'd17},
   parameter logic [15:0]      MAX_PAYLOAD = 16'd1480
) (
   input  logic               S_AXI_ACLK,
   input  logic               S_AXI_ARESETN,
   input  logic               S_HDR_TVALID,
   output logic               S_HDR_TREADY,
   input  logic [31:0]        S_HDR_TDATA,
   input  logic               S_HDR_TLAST,
   input  logic [NREQ-1:0]    S_PKT_TVALID,
   output logic [NREQ-1:0]    S_PKT_TREADY,
   input  logic [NREQ*32-1:0] S_PKT_TDATA,
   input  logic [NREQ-1:0]    S_PKT_TLAST,
   input  logic [NREQ*16-1:0] S_PKT_TBYTES,
   output logic               M_AXI_TVALID,
   input  logic               M_AXI_TREADY,
   output logic [31:0]        M_AXI_TDATA,
   output logic               M_AXI_TLAST,
   output logic [NREQ-1:0]    o_grant,
   output logic               o_oversize,
   output logic               o_hdr_err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   tx_state_e       st_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   gidx_q;
   logic [NREQ-1:0] grant_q;
   logic [2:0]      hidx_q;
   logic [15:0]     len_q;
   logic [7:0]      proto_q;
   logic            m_valid_q;
   logic            m_last_q;
   logic [31:0]     m_data_q;
   logic            ov_q;
   logic            herr_q;

   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   arb_idx;
   logic            arb_any;
   logic            ready_out;
   logic            hdr_hs;
   logic            pkt_hs;
   logic [31:0]     hdr_word;
   logic [31:0]     pkt_word;
   logic            pkt_last;
   logic [15:0]     req_bytes;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req_i (S_PKT_TVALID),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   // Output register can take a beat when empty or draining.
   assign ready_out    = !m_valid_q || M_AXI_TREADY;
   assign S_HDR_TREADY = (st_q == HDR) && ready_out;
   assign S_PKT_TREADY = (st_q == PAYLOAD && ready_out)
                         ? grant_q : '0;

   assign hdr_hs    = S_HDR_TVALID && S_HDR_TREADY;
   assign pkt_hs    = S_PKT_TVALID[gidx_q] && S_PKT_TREADY[gidx_q];
   assign pkt_word  = S_PKT_TDATA[gidx_q*32 +: 32];
   assign pkt_last  = S_PKT_TLAST[gidx_q];
   assign req_bytes = S_PKT_TBYTES[arb_idx*16 +: 16];

   always_comb begin
      hdr_word = S_HDR_TDATA;
      if (hidx_q == 3'(IPV4_LEN_WORD))
         hdr_word[15:0] = len_q;
      if (hidx_q == 3'(IPV4_PROTO_WORD))
         hdr_word[23:16] = proto_q;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         st_q      <= IDLE;
         rr_ptr_q  <= '0;
         gidx_q    <= '0;
         grant_q   <= '0;
         hidx_q    <= '0;
         len_q     <= '0;
         proto_q   <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         ov_q      <= 1'b0;
         herr_q    <= 1'b0;
      end else begin
         ov_q   <= 1'b0;
         herr_q <= 1'b0;

         if (hdr_hs) begin
            m_valid_q <= 1'b1;
            m_data_q  <= hdr_word;
            m_last_q  <= 1'b0;
         end else if (pkt_hs) begin
            m_valid_q <= 1'b1;
            m_data_q  <= pkt_word;
            m_last_q  <= pkt_last;
         end else if (M_AXI_TREADY) begin
            m_valid_q <= 1'b0;
         end

         unique case (st_q)
            IDLE: begin
               if (arb_any) begin
                  grant_q <= arb_gnt;
                  gidx_q  <= arb_idx;
                  len_q   <= req_bytes + 16'(IPV4_HDR_BYTES);
                  proto_q <= PROTOS[arb_idx*8 +: 8];
                  hidx_q  <= '0;
                  ov_q    <= req_bytes > MAX_PAYLOAD;
                  st_q    <= HDR;
               end
            end
            HDR: begin
               if (hdr_hs) begin
                  if (hidx_q != 3'd7)
                     hidx_q <= hidx_q + 3'd1;
                  if (S_HDR_TLAST) begin
                     herr_q <= hidx_q != 3'(IPV4_HDR_WORDS - 1);
                     st_q   <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (pkt_hs && pkt_last) begin
                  st_q     <= IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= (int'(gidx_q) == NREQ - 1)
                              ? '0 : gidx_q + 1'b1;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign M_AXI_TVALID = m_valid_q;
   assign M_AXI_TDATA  = m_data_q;
   assign M_AXI_TLAST  = m_last_q;
   assign o_grant      = grant_q;
   assign o_oversize   = ov_q;
   assign o_hdr_err    = herr_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: packet-level model of the scheduler output
// stream, checked word by word against udp_tx_sched.
module tb_udp_tx_sched;

   localparam int NR = 2;

   typedef struct {
      logic [15:0]      tb;
      int               nb;
      logic [5:0][31:0] d;
   } pkt_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hdr_v = 1'b0;
   logic          hdr_r;
   logic [31:0]   hdr_d = '0;
   logic          hdr_l = 1'b0;
   logic [1:0]    pkt_v = '0;
   logic [1:0]    pkt_r;
   logic [63:0]   pkt_d = '0;
   logic [1:0]    pkt_l = '0;
   logic [31:0]   pkt_b = '0;
   logic          m_v;
   logic          m_r = 1'b1;
   logic [31:0]   m_d;
   logic          m_l;
   logic [1:0]    gnt;
   logic          ovs;
   logic          herr;

   udp_tx_sched #(
      .NREQ        (2),
      .PROTOS      ({8'd6, 8'd17}),
      .MAX_PAYLOAD (16'd1480)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_HDR_TVALID  (hdr_v),
      .S_HDR_TREADY  (hdr_r),
      .S_HDR_TDATA   (hdr_d),
      .S_HDR_TLAST   (hdr_l),
      .S_PKT_TVALID  (pkt_v),
      .S_PKT_TREADY  (pkt_r),
      .S_PKT_TDATA   (pkt_d),
      .S_PKT_TLAST   (pkt_l),
      .S_PKT_TBYTES  (pkt_b),
      .M_AXI_TVALID  (m_v),
      .M_AXI_TREADY  (m_r),
      .M_AXI_TDATA   (m_d),
      .M_AXI_TLAST   (m_l),
      .o_grant       (gnt),
      .o_oversize    (ovs),
      .o_hdr_err     (herr)
   );

   always #5 clk = ~clk;

   logic [7:0]  proto_tab [NR] = '{8'h11, 8'h06};

   pkt_t        rq [NR][$];
   int          ppos [NR];
   int          beat [NR];
   logic [31:0] hq [$];
   logic        hlq [$];
   int          hpos;
   logic [31:0] exp_d [$];
   logic        exp_l [$];
   int          order [$];
   int          src_n;
   int          mptr;
   int          short_hdr;
   int          ov_exp, he_exp, ov_seen, he_seen;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   task automatic fail(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   task automatic clr();
      for (int k = 0; k < NR; k++) begin
         rq[k].delete();
         ppos[k] = 0;
         beat[k] = 0;
      end
      hq.delete();
      hlq.delete();
      exp_d.delete();
      exp_l.delete();
      order.delete();
      hpos = 0;
      src_n = 0;
      ov_exp = 0;
      he_exp = 0;
      ov_seen = 0;
      he_seen = 0;
   endtask

   task automatic add_pkt(input int k, input logic [15:0] tb,
                          input int nb);
      pkt_t p;
      p.tb = tb;
      p.nb = nb;
      for (int b = 0; b < 6; b++) p.d[b] = $urandom;
      rq[k].push_back(p);
   endtask

   // Packet-level model: round-robin order over pending packets,
   // then header words (patched) followed by payload words.
   task automatic build();
      int          used [NR];
      int          ptr, k, kk, hl;
      pkt_t        p;
      logic [31:0] w;
      ptr = mptr;
      hl = (short_hdr != 0) ? 6 : 7;
      for (int i = 0; i < NR; i++) used[i] = 0;
      forever begin
         k = -1;
         for (int i = 0; i < NR; i++) begin
            kk = (ptr + i) % NR;
            if (k < 0 && used[kk] < rq[kk].size()) k = kk;
         end
         if (k < 0) break;
         p = rq[k][used[k]];
         used[k]++;
         order.push_back(k);
         for (int wi = 0; wi < hl; wi++) begin
            w = $urandom;
            hq.push_back(w);
            hlq.push_back(wi == hl - 1);
            if (wi == 2) w[15:0] = p.tb + 16'd20;
            if (wi == 4) w[23:16] = proto_tab[k];
            exp_d.push_back(w);
            exp_l.push_back(1'b0);
         end
         for (int b = 0; b < p.nb; b++) begin
            exp_d.push_back(p.d[b]);
            exp_l.push_back(b == p.nb - 1);
         end
         if (p.tb > 16'd1480) ov_exp++;
         if (hl != 7) he_exp++;
         ptr = (k + 1) % NR;
      end
      mptr = ptr;
   endtask

   task automatic check_reset();
      chk("rst_m_valid", m_v, 0);
      chk("rst_m_last", m_l, 0);
      chk("rst_m_data", m_d, 0);
      chk("rst_grant", gnt, 0);
      chk("rst_oversize", ovs, 0);
      chk("rst_hdr_err", herr, 0);
      chk("rst_hdr_ready", hdr_r, 0);
      chk("rst_pkt_ready", pkt_r, 0);
   endtask

   // rmode: 0 ready high, 1 random, 2 pattern 1,0,0,1.
   // vmode: 0 sources always valid, 1 random mid-packet gaps.
   task automatic run(input int rmode, input int vmode,
                      input int stop_beats, input int budget);
      int          pb, last_hs;
      logic        stall, pl, last_l;
      logic [31:0] pd;
      logic [1:0]  pg;
      logic [3:0]  pat;
      pb = 0;
      last_hs = -1;
      last_l = 1'b0;
      stall = 1'b0;
      pd = '0;
      pl = 1'b0;
      pg = '0;
      pat = 4'b1001;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         case (rmode)
            0: m_r = 1'b1;
            1: m_r = ($urandom_range(0, 2) != 0);
            default: m_r = pat[n % 4];
         endcase
         hdr_v = (hpos < hq.size()) &&
                 (vmode == 0 || $urandom_range(0, 3) != 0);
         hdr_d = (hpos < hq.size()) ? hq[hpos] : '0;
         hdr_l = (hpos < hq.size()) ? hlq[hpos] : 1'b0;
         for (int k = 0; k < NR; k++) begin
            if (ppos[k] < rq[k].size()) begin
               pkt_v[k] = (beat[k] == 0) || (vmode == 0) ||
                          ($urandom_range(0, 2) != 0);
               pkt_d[k*32 +: 32] = rq[k][ppos[k]].d[beat[k]];
               pkt_l[k] = (beat[k] == rq[k][ppos[k]].nb - 1);
               pkt_b[k*16 +: 16] = rq[k][ppos[k]].tb;
            end else begin
               pkt_v[k] = 1'b0;
            end
         end
         #1;
         if (stall) begin
            chk("hold_data", m_d, pd);
            chk("hold_last", m_l, pl);
         end
         if (m_v && m_r) begin
            if (exp_d.size() == 0) begin
               fail("extra_output_word");
            end else begin
               chk("out_data", m_d, exp_d[0]);
               chk("out_last", m_l, exp_l[0]);
               if (rmode == 0 && vmode == 0 && last_hs >= 0)
                  chk("out_spacing", n - last_hs, last_l ? 2 : 1);
               last_hs = n;
               last_l = exp_l[0];
               void'(exp_d.pop_front());
               void'(exp_l.pop_front());
            end
         end
         if (hdr_r || (|pkt_r)) begin
            if (src_n < order.size())
               chk("grant", gnt, 2'b01 << order[src_n]);
            chk("lane_ready", pkt_r & ~gnt, 0);
         end
         if (ovs) begin
            ov_seen++;
            chk("oversize_timing", {pg == 2'b00, gnt != 2'b00}, 2'b11);
         end
         if (herr) he_seen++;
         if (hdr_v && hdr_r) hpos++;
         for (int k = 0; k < NR; k++) begin
            if (pkt_v[k] && pkt_r[k]) begin
               pb++;
               if (pkt_l[k]) begin
                  beat[k] = 0;
                  ppos[k]++;
                  src_n++;
               end else begin
                  beat[k]++;
               end
            end
         end
         stall = m_v && !m_r;
         pd = m_d;
         pl = m_l;
         pg = gnt;
         if (stop_beats > 0 && pb >= stop_beats) return;
         if (exp_d.size() == 0 && hpos == hq.size() &&
             ppos[0] == rq[0].size() && ppos[1] == rq[1].size()) begin
            hdr_v = 1'b0;
            pkt_v = '0;
            m_r = 1'b1;
            repeat (2) @(negedge clk);
            #1;
            chk("tail_idle", m_v, 0);
            chk("oversize_count", ov_seen, ov_exp);
            chk("hdr_err_count", he_seen, he_exp);
            return;
         end
      end
      fail("phase_timeout");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      mptr = 0;
      short_hdr = 0;
      clr();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;

      // Contention: grants 0,1,0 with per-requester protocols.
      clr();
      add_pkt(0, 16'd8, 2);
      add_pkt(0, 16'd8, 2);
      add_pkt(1, 16'd8, 2);
      build();
      chk("model_order0", order[0], 0);
      chk("model_order1", order[1], 1);
      chk("model_order2", order[2], 0);
      chk("model_proto_a", exp_d[4][23:16], 8'h11);
      chk("model_proto_b", exp_d[13][23:16], 8'h06);
      run(0, 0, 0, 500);

      // Single packet, constant ready.
      clr();
      add_pkt(0, 16'd8, 2);
      build();
      chk("model_words", exp_d.size(), 9);
      chk("model_len", exp_d[2][15:0], 16'h001C);
      chk("model_proto", exp_d[4][23:16], 8'h11);
      chk("model_last8", exp_l[8], 1);
      chk("model_last7", exp_l[7], 0);
      run(0, 0, 0, 500);

      // Backpressure across the header.
      clr();
      add_pkt(1, 16'd12, 3);
      build();
      chk("model_len_bp", exp_d[2][15:0], 16'h0020);
      run(2, 0, 0, 500);

      // Oversize request still sent.
      clr();
      add_pkt(0, 16'd1500, 2);
      build();
      chk("model_len_ov", exp_d[2][15:0], 16'h05F0);
      chk("model_ov_cnt", ov_exp, 1);
      run(0, 0, 0, 500);

      // Short header: TLAST on word 5.
      clr();
      short_hdr = 1;
      add_pkt(1, 16'd4, 1);
      build();
      chk("model_short_words", exp_d.size(), 7);
      chk("model_he_cnt", he_exp, 1);
      run(0, 0, 0, 500);
      short_hdr = 0;

      // Reset mid-packet; rr_ptr must return to 0.
      clr();
      add_pkt(0, 16'd8, 1);
      build();
      run(0, 0, 0, 500);
      clr();
      add_pkt(1, 16'd12, 3);
      build();
      run(0, 0, 2, 500);
      rst_n = 1'b0;
      hdr_v = 1'b0;
      pkt_v = '0;
      @(negedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;
      clr();
      mptr = 0;
      add_pkt(0, 16'd16, 2);
      add_pkt(1, 16'd20, 2);
      build();
      chk("model_rst_order", order[0], 0);
      run(0, 0, 0, 500);

      // Randomized traffic with stalls on both sides.
      for (int ph = 0; ph < 3; ph++) begin
         clr();
         for (int k = 0; k < NR; k++) begin
            int np;
            np = $urandom_range(1, 4);
            for (int i = 0; i < np; i++) begin
               if ($urandom_range(0, 4) == 0)
                  add_pkt(k, 16'(1481 + $urandom_range(0, 40)),
                          $urandom_range(1, 6));
               else
                  add_pkt(k, 16'($urandom_range(1, 64)),
                          $urandom_range(1, 6));
            end
         end
         build();
         run(1, 1, 0, 4000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
